buffer_write_arbiter: RTL and testbench
=======================================

// Module: buffer_write_arbiter
// PURPOSE
//   Round-robin arbiter sharing the single write port of one flexiable_buffer among NUM_REQ producers
//   (e.g. several UART RX channels feeding one width-converting buffer). Grants one producer at a time
//   for a burst of up to MAX_BURST words. Drives buf_wr_en/buf_data and honours buf_full back-pressure.
// PARAMETERS
//   NUM_REQ    4   number of requesters (2..8)
//   WIDTH      8   data word width, equals the buffer's IN_WIDTH
//   MAX_BURST  4   max words accepted per grant before forced re-arbitration (1..255)
//   TIMEOUT    64  cycles of continuous buf_full during a grant before the grant is revoked (ARB_TIMEOUT_EN only)
// PORTS
//   clk        in   1               clock, rising edge
//   rst        in   1               asynchronous reset, active-low
//   req        in   NUM_REQ         req[i]=1: producer i has a word on its data slice
//   req_data   in   NUM_REQ*WIDTH   producer i word at [i*WIDTH +: WIDTH]
//   grant      out  NUM_REQ         registered one-hot grant, 0 when idle
//   ack        out  NUM_REQ         ack[i]=1: producer i word consumed this cycle (combinational)
//   buf_wr_en  out  1               write strobe to buffer
//   buf_data   out  WIDTH           word to buffer, mux of granted slice
//   buf_full   in   1               buffer full flag
//   busy       out  1               grant active
//   timeout    out  1               1-cycle pulse on grant revocation (tied 0 without ARB_TIMEOUT_EN)
// BEHAVIOUR
//   - Reset (rst=0, async): state=IDLE, grant=0, ptr=NUM_REQ-1, beat_cnt=0, stall_cnt=0; ack, buf_wr_en,
//     busy, timeout all 0; buf_data=0.
//   - States: IDLE, BURST. One dead cycle (IDLE) between consecutive grants.
//   - IDLE: if |req, pick the first set req[i] searching ptr+1, ptr+2, ... modulo NUM_REQ; register grant=onehot(i),
//     ptr<=i, beat_cnt<=0, go BURST. If req==0, stay IDLE. Latency req rise -> first ack >= 1 cycle.
//   - Transfer: fire = busy & req[g] & !buf_full. fire -> buf_wr_en=1, ack[g]=1, buf_data=slice g, beat_cnt++.
//     buf_wr_en is never asserted while buf_full=1; buf_data=0 when !fire.
//   - BURST exit to IDLE (grant<=0 next edge) when: req[g]=0 at a clock edge, OR fire with beat_cnt==MAX_BURST-1,
//     OR timeout. Exit and final fire in the same cycle: word is still accepted.
//   - Ungranted producers never see ack; they hold req/data stable until acked.
//   - buf_full held during BURST: grant held, no fire, beat_cnt frozen.
//   - req dropping mid-burst ends the grant; ptr already advanced, so that producer is lowest priority next round.
//   - Fairness: with all req high, grants rotate 0,1,2,...,NUM_REQ-1,0 each burst.
//   - Reset mid-burst: grant drops asynchronously; a word presented that cycle is not acked.
// CONFIGURATION
//   ARB_TIMEOUT_EN defined: stall_cnt counts consecutive BURST cycles with buf_full=1 and req[g]=1, cleared by
//     fire or leaving BURST; when stall_cnt==TIMEOUT-1 and still stalled, pulse timeout=1 and go IDLE.
//   ARB_TIMEOUT_EN undefined: no stall_cnt; grant held indefinitely under buf_full; timeout tied 0.
// STRUCTURE
//   Package buffer_arb_pkg: state enum {IDLE, BURST}; localparam widths PTR_W=$clog2(NUM_REQ),
//     BEAT_W=$clog2(MAX_BURST+1); function onehot-to-index.
//   Sub-module rr_priority_picker (pure combinational: req, ptr -> one-hot next grant); FSM, counters and
//     datapath mux stay in buffer_write_arbiter.
// TESTING
//   1 Reset: rst=0 with req=4'b1111 -> grant=0, ack=0, buf_wr_en=0, busy=0; release -> first grant=4'b0001.
//   2 All req=1, MAX_BURST=4, buf_full=0 -> 4 writes from 0, 1 idle cycle, 4 from 1, ... sequence 0,1,2,3,0.
//   3 req=4'b0100 only, producer 2 drops req after 2 words -> 2 acks, grant 0 next edge, 2 words in buffer.
//   4 Grant to 1, buf_full=1 for 10 cycles mid-burst -> buf_wr_en=0, grant held, beat_cnt frozen, resumes after.
//   5 ARB_TIMEOUT_EN, TIMEOUT=64, buf_full stuck 1 -> timeout pulses once on 64th stalled cycle, grant=0 next;
//     without macro grant held >200 cycles, timeout=0.
//   6 rst asserted mid-burst after word 2 -> grant/buf_wr_en drop at once; after release arbitration restarts from 0.

Source files
------------

// File: rtl/buffer_arb_pkg.sv
// rtl/buffer_arb_pkg.sv - shared types and helpers for the buffer write arbiter
// Purpose: FSM state encoding, requester limits and a one-hot to index helper
//          used by buffer_write_arbiter.
// Ports:   none (package).
package buffer_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Widest requester vector the arbiter supports; index helpers are sized for it.
  localparam int MAX_REQ = 8;
  localparam int IDX_W   = $clog2(MAX_REQ);

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin next-grant picker
// Purpose: selects the first asserted request searching ptr+1, ptr+2, ...
//          modulo NUM_REQ and returns it one-hot (all zero when req is 0).
// Ports:   req   in  NUM_REQ  request vector
//          ptr   in  PTR_W    index of the most recently granted requester
//          grant out NUM_REQ  one-hot pick
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic found;

  // Two passes avoid modulo arithmetic: first the indices above ptr, then wrap
  // around to the indices at or below ptr (ptr itself is lowest priority).
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (PTR_W'(i) > ptr)) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (PTR_W'(i) <= ptr)) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/buffer_write_arbiter.sv
// rtl/buffer_write_arbiter.sv - round-robin burst arbiter for one buffer write port
// Purpose: shares a single buffer write port among NUM_REQ producers, granting
//          one producer at a time for up to MAX_BURST words, honouring buf_full.
// Ports:   clk        in   clock, rising edge
//          rst        in   asynchronous reset, active-low
//          req        in   per-producer word-valid
//          req_data   in   producer i word at [i*WIDTH +: WIDTH]
//          grant      out  registered one-hot grant, 0 when idle
//          ack        out  per-producer word consumed this cycle
//          buf_wr_en  out  buffer write strobe
//          buf_data   out  word to buffer (0 when not writing)
//          buf_full   in   buffer full flag
//          busy       out  grant active
//          timeout    out  one-cycle pulse when a stalled grant is revoked
// Build option: ARB_TIMEOUT_EN adds the stall timer that revokes a grant after
//          TIMEOUT consecutive stalled cycles; without it timeout is tied 0.
module buffer_write_arbiter
  import buffer_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     buf_wr_en,
  output logic [WIDTH-1:0]         buf_data,
  input  logic                     buf_full,
  output logic                     busy,
  output logic                     timeout
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int BEAT_W = $clog2(MAX_BURST + 1);

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;

  logic [NUM_REQ-1:0]  pick;
  logic [MAX_REQ-1:0]  pick_ext;
  logic                req_g;
  logic                fire;
  logic                last_beat;
  logic                revoke;
  logic [WIDTH-1:0]    slice_mux;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req   (req),
    .ptr   (ptr_q),
    .grant (pick)
  );

  always_comb begin
    req_g     = |(req & grant_q);
    fire      = (state_q == BURST) && req_g && !buf_full;
    last_beat = fire && (beat_cnt_q == BEAT_W'(MAX_BURST - 1));
    slice_mux = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) slice_mux = slice_mux | req_data[i*WIDTH +: WIDTH];
    end
    pick_ext                = '0;
    pick_ext[NUM_REQ-1:0]   = pick;
  end

`ifdef ARB_TIMEOUT_EN
  localparam int STALL_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               stalled;

  // Counts consecutive cycles where the granted producer wants to write but the
  // buffer is full; any fire or leaving BURST clears it.
  always_comb begin
    stalled = (state_q == BURST) && req_g && buf_full;
    revoke  = stalled && (stall_cnt_q == STALL_W'(TIMEOUT - 1));
    if (stalled && !revoke) stall_cnt_d = stall_cnt_q + STALL_W'(1);
    else                    stall_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end
`else
  // TIMEOUT only matters when the stall timer is built in.
  localparam int unused_timeout_param = TIMEOUT;
  assign revoke = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      ptr_q      <= PTR_W'(NUM_REQ - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d    = BURST;
          grant_d    = pick;
          ptr_d      = PTR_W'(onehot_to_idx(pick_ext));
          beat_cnt_d = '0;
        end
      end
      BURST: begin
        if (fire) beat_cnt_d = beat_cnt_q + BEAT_W'(1);
        // The final word of a burst is still accepted in the exit cycle.
        if (!req_g || last_beat || revoke) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    grant     = grant_q;
    busy      = (state_q == BURST);
    buf_wr_en = fire;
    ack       = fire ? grant_q : '0;
    buf_data  = fire ? slice_mux : '0;
    timeout   = revoke;
  end

endmodule

// File: tb/tb_buffer_write_arbiter.sv
// tb/tb_buffer_write_arbiter.sv - self-checking bench for buffer_write_arbiter
module tb_buffer_write_arbiter;

  localparam int NR = 4;
  localparam int W  = 8;
  localparam int MB = 4;
  localparam int TO = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req;
  logic [NR*W-1:0] req_data;
  logic [NR-1:0]   grant;
  logic [NR-1:0]   ack;
  logic            buf_wr_en;
  logic [W-1:0]    buf_data;
  logic            buf_full;
  logic            busy;
  logic            timeout;

  buffer_write_arbiter #(
    .NUM_REQ   (NR),
    .WIDTH     (W),
    .MAX_BURST (MB),
    .TIMEOUT   (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .grant     (grant),
    .ack       (ack),
    .buf_wr_en (buf_wr_en),
    .buf_data  (buf_data),
    .buf_full  (buf_full),
    .busy      (busy),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  logic [W-1:0]  exp_q [NR][$];
  int            gseq[$];
  int            burst_q[$];
  int            dur_q[$];
  int            gap_q[$];
  logic [NR-1:0] prev_grant;
  int            beats, dur, idle_run, written;
  logic          rst_v, full_v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int oh2i(input logic [NR-1:0] v);
    int r = 0;
    for (int i = 0; i < NR; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic bit all_empty();
    bit e = 1'b1;
    for (int i = 0; i < NR; i++) if (exp_q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic drive();
    rst      = rst_v;
    buf_full = full_v;
    for (int i = 0; i < NR; i++) begin
      req[i]            = (exp_q[i].size() != 0);
      req_data[i*W +: W] = (exp_q[i].size() != 0) ? exp_q[i][0] : '0;
    end
  endtask

  task automatic sample();
    int i;
    if (grant !== prev_grant) begin
      if (prev_grant != 0) begin
        burst_q.push_back(beats);
        dur_q.push_back(dur);
      end
      if (grant != 0) begin
        gseq.push_back(oh2i(grant));
        gap_q.push_back(idle_run);
      end
      beats    = 0;
      dur      = 0;
      idle_run = 0;
    end
    if (grant != 0) dur++;
    else            idle_run++;
    prev_grant = grant;
    if (buf_wr_en) begin
      beats++;
      written++;
      chk("wr_while_full", buf_full, 0);
      chk("ack_vs_grant", ack, grant);
      i = oh2i(ack);
      if (exp_q[i].size() == 0) chk("extra_word", 1, 0);
      else                      chk("word_data", buf_data, exp_q[i].pop_front());
    end else begin
      chk("quiet_ack", ack, 0);
      chk("quiet_data", buf_data, 0);
    end
  endtask

  // One clock: inputs change just after the rising edge, outputs are read at the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    sample();
  endtask

  task automatic clear_logs();
    gseq.delete();
    burst_q.delete();
    dur_q.delete();
    gap_q.delete();
    prev_grant = grant;
    beats      = 0;
    dur        = 0;
    idle_run   = 0;
    written    = 0;
  endtask

  task automatic run_until_idle(input int max_cyc);
    bit done = 1'b0;
    for (int n = 0; n < max_cyc && !done; n++) begin
      step();
      if (all_empty() && grant == 0) done = 1'b1;
    end
    if (!done) chk("idle_budget", 1, 0);
  endtask

  task automatic wait_writes(input int target, input int max_cyc);
    bit done = 1'b0;
    for (int n = 0; n < max_cyc && !done; n++) begin
      step();
      if (written >= target) done = 1'b1;
    end
    if (!done) chk("write_budget", 1, 0);
  endtask

  task automatic load(input int p, input int n);
    for (int k = 0; k < n; k++) exp_q[p].push_back(W'($urandom));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_v  = 1'b0;
    full_v = 1'b0;
    for (int p = 0; p < NR; p++) load(p, 2 * MB);
    drive();
    prev_grant = '0;

    // Reset with every producer requesting
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_grant", grant, 0);
      chk("rst_ack", ack, 0);
      chk("rst_wr_en", buf_wr_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_timeout", timeout, 0);
    end

    // Fairness: full bursts rotating 0,1,2,3,0,1,2,3 with one dead cycle between
    clear_logs();
    rst_v = 1'b1;
    run_until_idle(120);
    chk("t2_ngrants", gseq.size(), 8);
    for (int k = 0; k < gseq.size(); k++) chk("t2_order", gseq[k], k % NR);
    for (int k = 0; k < burst_q.size(); k++) chk("t2_burst_len", burst_q[k], MB);
    for (int k = 0; k < dur_q.size(); k++) chk("t2_burst_cycles", dur_q[k], MB);
    for (int k = 1; k < gap_q.size(); k++) chk("t2_dead_cycle", gap_q[k], 1);
    chk("t2_words", written, 8 * MB);

    // Producer 2 alone with two words: request drops and the grant ends next edge
    clear_logs();
    load(2, 2);
    run_until_idle(20);
    chk("t3_ngrants", gseq.size(), 1);
    chk("t3_grant", (gseq.size() > 0) ? gseq[0] : -1, 2);
    chk("t3_words", written, 2);
    chk("t3_burst_len", (burst_q.size() > 0) ? burst_q[0] : -1, 2);
    chk("t3_burst_cycles", (dur_q.size() > 0) ? dur_q[0] : -1, 3);

    // Producer 1 with buf_full held 10 cycles after two words
    clear_logs();
    load(1, MB);
    wait_writes(2, 20);
    full_v = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("t4_hold_grant", grant, 4'b0010);
      chk("t4_busy", busy, 1);
    end
    full_v = 1'b0;
    run_until_idle(30);
    chk("t4_ngrants", gseq.size(), 1);
    chk("t4_grant", (gseq.size() > 0) ? gseq[0] : -1, 1);
    chk("t4_burst_len", (burst_q.size() > 0) ? burst_q[0] : -1, MB);
    chk("t4_burst_cycles", (dur_q.size() > 0) ? dur_q[0] : -1, MB + 10);
    chk("t4_words", written, MB);

    // Producer 3 with buf_full stuck after its first word
    clear_logs();
    load(3, MB);
    wait_writes(1, 20);
    full_v = 1'b1;
`ifdef ARB_TIMEOUT_EN
    for (int k = 1; k <= TO; k++) begin
      step();
      chk("t5_timeout_pulse", timeout, (k == TO) ? 1 : 0);
    end
    step();
    chk("t5_revoked", grant, 0);
    chk("t5_pulse_once", timeout, 0);
    full_v = 1'b0;
    run_until_idle(40);
    chk("t5_ngrants", gseq.size(), 2);
    chk("t5_first_len", (burst_q.size() > 0) ? burst_q[0] : -1, 1);
    chk("t5_second_len", (burst_q.size() > 1) ? burst_q[1] : -1, MB - 1);
`else
    for (int k = 0; k < 210; k++) begin
      step();
      chk("t5_hold_grant", grant, 4'b1000);
      chk("t5_no_timeout", timeout, 0);
    end
    full_v = 1'b0;
    run_until_idle(40);
    chk("t5_ngrants", gseq.size(), 1);
    chk("t5_burst_len", (burst_q.size() > 0) ? burst_q[0] : -1, MB);
`endif
    chk("t5_words", written, MB);

    // Reset during a burst of producer 0 while producer 1 waits
    clear_logs();
    load(0, MB);
    load(1, 1);
    wait_writes(2, 20);
    rst_v = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_pre_grant", grant, 4'b0001);
    drive();
    #1;
    chk("t6_async_grant", grant, 0);
    chk("t6_async_wr_en", buf_wr_en, 0);
    chk("t6_async_ack", ack, 0);
    chk("t6_async_busy", busy, 0);
    @(negedge clk);
    sample();
    step();
    clear_logs();
    rst_v = 1'b1;
    run_until_idle(40);
    chk("t6_ngrants", gseq.size(), 2);
    chk("t6_restart_0", (gseq.size() > 0) ? gseq[0] : -1, 0);
    chk("t6_then_1", (gseq.size() > 1) ? gseq[1] : -1, 1);
    chk("t6_rest_len", (burst_q.size() > 0) ? burst_q[0] : -1, MB - 2);
    chk("t6_words", written, MB - 1);

    chk("all_drained", all_empty(), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
